// File: rtl/key_cmd_pkg.sv
// Shared types and key decoding helpers for the keypad command scheduler.
package key_cmd_pkg;

    typedef enum logic [2:0] {
        UP    = 3'd0,
        LEFT  = 3'd1,
        DOWN  = 3'd2,
        RIGHT = 3'd3,
        FIRE  = 3'd4
    } cmd_op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

    localparam logic [3:0] KEY_UP    = 4'd0;
    localparam logic [3:0] KEY_LEFT  = 4'd1;
    localparam logic [3:0] KEY_DOWN  = 4'd2;
    localparam logic [3:0] KEY_RIGHT = 4'd3;
    localparam logic [3:0] KEY_A     = 4'd4;
    localparam logic [3:0] KEY_W     = 4'd5;
    localparam logic [3:0] KEY_S     = 4'd6;
    localparam logic [3:0] KEY_D     = 4'd7;
    localparam logic [3:0] KEY_SPACE = 4'd8;
    localparam logic [3:0] KEY_ENTER = 4'd9;

    // P1 owns the w/a/s/d + space cluster, everything else belongs to P0
    function automatic logic key_to_player(input logic [3:0] k);
        return (k >= KEY_A) && (k <= KEY_SPACE);
    endfunction

    function automatic cmd_op_t key_to_op(input logic [3:0] k);
        cmd_op_t op;
        op = FIRE;
        case (k)
            KEY_UP,    KEY_W: op = UP;
            KEY_LEFT,  KEY_A: op = LEFT;
            KEY_DOWN,  KEY_S: op = DOWN;
            KEY_RIGHT, KEY_D: op = RIGHT;
            default:          op = FIRE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/key_cmd_player_track.sv
// Per-player move auto-repeat and fire cooldown tracker.
// KEY_CMD_STATS_EN adds drop_inc, flagging set requests that hit an already-set pending flag.
module key_cmd_player_track
    import key_cmd_pkg::*;
#(
    parameter int REPEAT_TICKS  = 8,
    parameter int FIRE_COOLDOWN = 30,
    parameter int CD_W          = 6
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    press_dir,
    input  logic    press_fire,
    input  logic    release_dir,
    input  cmd_op_t press_op,
    input  cmd_op_t release_op,
    input  logic    frame_tick,
    input  logic    offer_move,
    input  logic    clr_move,
    input  logic    clr_fire,
    output logic    move_pend,
    output logic    fire_pend,
    output cmd_op_t held_dir
`ifdef KEY_CMD_STATS_EN
    ,
    output logic [1:0] drop_inc
`endif
);

    logic            held;
    logic            move_rearm;
    logic [CD_W-1:0] rpt_cnt;
    logic [CD_W-1:0] cd_cnt;
    logic            rel_hit;
    logic            rpt_evt;
    logic            set_move;
    logic            set_fire;

    assign rel_hit  = release_dir && held && (release_op == held_dir);
    assign rpt_evt  = held && frame_tick && !press_dir && !rel_hit && (rpt_cnt == CD_W'(1));
    assign set_move = press_dir || rpt_evt;
    assign set_fire = press_fire && (cd_cnt == '0);

`ifdef KEY_CMD_STATS_EN
    assign drop_inc = {set_fire && fire_pend && !clr_fire,
                       set_move && move_pend && !clr_move && (!offer_move || move_rearm)};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held       <= 1'b0;
            held_dir   <= UP;
            rpt_cnt    <= '0;
            cd_cnt     <= '0;
            move_pend  <= 1'b0;
            move_rearm <= 1'b0;
            fire_pend  <= 1'b0;
        end else begin
            if (press_dir) begin
                held     <= 1'b1;
                held_dir <= press_op;
                rpt_cnt  <= CD_W'(REPEAT_TICKS);
            end else if (rel_hit) begin
                held <= 1'b0;
            end else if (held && frame_tick) begin
                rpt_cnt <= (rpt_cnt == CD_W'(1)) ? CD_W'(REPEAT_TICKS) : rpt_cnt - CD_W'(1);
            end

            // a move request arriving while this player's move is on the channel survives its acceptance
            if (clr_move) begin
                move_pend  <= set_move || move_rearm;
                move_rearm <= 1'b0;
            end else if (set_move) begin
                move_pend <= 1'b1;
                if (move_pend && offer_move)
                    move_rearm <= 1'b1;
            end

            if (set_fire)
                fire_pend <= 1'b1;
            else if (clr_fire)
                fire_pend <= 1'b0;

            if (clr_fire)
                cd_cnt <= CD_W'(FIRE_COOLDOWN);
            else if (frame_tick && (cd_cnt != '0))
                cd_cnt <= cd_cnt - CD_W'(1);
        end
    end

endmodule

// File: rtl/key_cmd_scheduler.sv
// Keypad-to-command scheduler: two player trackers round-robin arbitrated onto one valid/ready channel.
// Build option KEY_CMD_STATS_EN adds the saturating drop_count output.
module key_cmd_scheduler
    import key_cmd_pkg::*;
#(
    parameter int REPEAT_TICKS  = 8,
    parameter int FIRE_COOLDOWN = 30,
    parameter int CD_W          = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key,
    input  logic       keyIsValid,
    input  logic       frame_tick,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       cmd_player,
    output logic [2:0] cmd_op
`ifdef KEY_CMD_STATS_EN
    ,
    output logic [7:0] drop_count
`endif
);

    logic [3:0] key_p0, key_p1;
    logic       vld_p0, vld_p1;

    // p0: registered decoder inputs, p1: previous sample for edge/change detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_p0 <= '0;
            key_p1 <= '0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            key_p0 <= key;
            vld_p0 <= keyIsValid;
            key_p1 <= key_p0;
            vld_p1 <= vld_p0;
        end
    end

    logic       press_evt, release_evt;
    cmd_op_t    press_op, rel_op;
    logic [1:0] press_sel, rel_sel, cmd_sel;
    logic [1:0] press_dir_v, press_fire_v, rel_dir_v;
    logic [1:0] offer_mv_v, clr_mv_v, clr_fi_v;
    logic [1:0] move_pend, fire_pend, req;
    cmd_op_t    held_dir [2];
    arb_state_t state;
    logic       rr_ptr, accept, sel;
    cmd_op_t    sel_op;

    assign press_evt   = vld_p0 && (key_p0 <= KEY_ENTER) && (!vld_p1 || (key_p0 != key_p1));
    assign release_evt = vld_p1 && !vld_p0 && (key_p1 <= KEY_ENTER);
    assign press_op    = key_to_op(key_p0);
    assign rel_op      = key_to_op(key_p1);
    assign press_sel   = key_to_player(key_p0) ? 2'b10 : 2'b01;
    assign rel_sel     = key_to_player(key_p1) ? 2'b10 : 2'b01;
    assign cmd_sel     = cmd_player ? 2'b10 : 2'b01;

    assign press_dir_v  = press_sel & {2{press_evt && (press_op != FIRE)}};
    assign press_fire_v = press_sel & {2{press_evt && (press_op == FIRE)}};
    assign rel_dir_v    = rel_sel & {2{release_evt && (rel_op != FIRE)}};
    assign accept       = (state == OFFER) && cmd_ready;
    assign offer_mv_v   = cmd_sel & {2{(state == OFFER) && (cmd_op != FIRE)}};
    assign clr_mv_v     = offer_mv_v & {2{accept}};
    assign clr_fi_v     = cmd_sel & {2{accept && (cmd_op == FIRE)}};

`ifdef KEY_CMD_STATS_EN
    logic [1:0] drop_inc [2];
`endif

    for (genvar p = 0; p < 2; p++) begin : g_trk
        key_cmd_player_track #(
            .REPEAT_TICKS (REPEAT_TICKS),
            .FIRE_COOLDOWN(FIRE_COOLDOWN),
            .CD_W         (CD_W)
        ) u_trk (
            .clk        (clk),
            .reset      (reset),
            .press_dir  (press_dir_v[p]),
            .press_fire (press_fire_v[p]),
            .release_dir(rel_dir_v[p]),
            .press_op   (press_op),
            .release_op (rel_op),
            .frame_tick (frame_tick),
            .offer_move (offer_mv_v[p]),
            .clr_move   (clr_mv_v[p]),
            .clr_fire   (clr_fi_v[p]),
            .move_pend  (move_pend[p]),
            .fire_pend  (fire_pend[p]),
            .held_dir   (held_dir[p])
`ifdef KEY_CMD_STATS_EN
            ,
            .drop_inc   (drop_inc[p])
`endif
        );
    end

    assign req = move_pend | fire_pend;

    always_comb begin
        sel = rr_ptr;
        if (req == 2'b01)
            sel = 1'b0;
        else if (req == 2'b10)
            sel = 1'b1;
        sel_op = fire_pend[sel] ? FIRE : held_dir[sel];
    end

    // arbiter: latch one player's command, hold it stable until accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cmd_valid  <= 1'b0;
            cmd_player <= 1'b0;
            cmd_op     <= '0;
            rr_ptr     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req != 2'b00) begin
                    cmd_player <= sel;
                    cmd_op     <= sel_op;
                    cmd_valid  <= 1'b1;
                    state      <= OFFER;
                end
                OFFER: if (cmd_ready) begin
                    cmd_valid <= 1'b0;
                    rr_ptr    <= ~cmd_player;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KEY_CMD_STATS_EN
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [2:0] b);
        logic [8:0] s;
        s = {1'b0, a} + 9'(b);
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    logic [2:0] drop_sum;
    assign drop_sum = 3'(drop_inc[0][0]) + 3'(drop_inc[0][1]) + 3'(drop_inc[1][0]) + 3'(drop_inc[1][1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            drop_count <= '0;
        else
            drop_count <= sat_add8(drop_count, drop_sum);
    end
`endif

endmodule
